uno_seq: RTL and testbench
==========================

Name: uno_seq

Overview:
- Command sequencer and initiator for the unified PE (MAC/div/exp/log).
- Accepts operation commands and operand beats from upstream, then drives the PE control interface cycle by cycle: op, first/last-cycle flags, accumulate enable, coefficient stream and held operands.
- Captures the PE accumulator output and returns it on a valid/ready result channel.
- Holds a programmable per-op coefficient table for the Horner-style polynomial ops.

Parameters:
MAC_BW, 12, PE operand width (4.8 fixed point); result width is 2*MAC_BW.
TERMS, 4, polynomial coefficients per non-MAC op; must be 2..15.
LEN_W, 8, width of the MAC length field.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_op  in  2  00 MAC, 01 div, 10 exp, 11 log
cmd_len  in  LEN_W  MAC beat count (ignored for other ops)
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat ready
in_x  in  MAC_BW  operand X
in_y  in  MAC_BW  operand Y
in_z  in  2*MAC_BW  MAC initial addend
cfg_we  in  1  coefficient write strobe
cfg_op  in  2  table select (01/10/11; 00 ignored)
cfg_idx  in  4  coefficient index 0..TERMS-1 (out of range ignored)
cfg_data  in  MAC_BW  coefficient value
pe_en  out  1  PE step qualifier (mac register update)
pe_op  out  2  op to PE
pe_x  out  MAC_BW  registered X
pe_y  out  MAC_BW  registered Y
pe_z  out  2*MAC_BW  registered Z
pe_coeff  out  MAC_BW  coefficient for this step
pe_first_cycle  out  1  first polynomial step
pe_last_cycle  out  1  last polynomial step
pe_acc_en  out  1  MAC accumulate (1) vs load Z (0)
pe_result  in  2*MAC_BW  PE accumulator output (macO)
res_valid  out  1  result valid
res_ready  in  1  result ready
res_data  out  2*MAC_BW  captured result

Behaviour:
- Reset (synchronous, active-high): every output goes to 0, FSM goes to IDLE, counters clear, coefficient table clears to 0.
  - Applies on the next edge from any state, including mid-command.
  - No result is produced for an aborted command.
  - cmd_ready rises the first cycle after rst deasserts.
- FSM states: IDLE, STREAM, FETCH, STEP, CAPTURE, DONE.
- IDLE:
  - cmd_ready=1; all other handshake and PE strobes are 0.
  - On cmd_valid&cmd_ready, latch op and len (len 0 is treated as 1).
  - MAC goes to STREAM; other ops go to FETCH.
- STREAM (MAC):
  - in_ready=1.
  - Beat accepted in cycle t: pe_x/pe_y/pe_z are loaded from in_*, and in cycle t+1 pe_en=1, pe_op=00, pe_acc_en=0 for beat 1 and 1 for later beats.
  - No beat in cycle t means pe_en=0 in t+1 (stall; counters hold).
  - After the len-th beat, go to CAPTURE; the final pe_en pulse occurs in CAPTURE's first cycle.
- FETCH (poly):
  - in_ready=1 for exactly one beat; latch X and Y, which are held on pe_x/pe_y until DONE. pe_z=0.
  - Then go to STEP with s=0.
- STEP:
  - pe_en=1 for TERMS+1 consecutive cycles, s=0..TERMS, with no stalls; pe_op = latched op.
  - s=0: pe_first_cycle=1.
  - s=TERMS: pe_last_cycle=1 and pe_coeff=0.
  - Otherwise pe_coeff = coef[op][TERMS-1-s].
  - After s=TERMS, go to CAPTURE.
- CAPTURE: one cycle after the final pe_en cycle, res_data <= pe_result; go to DONE.
- Latency:
  - MAC: last beat accepted at t gives res_valid at t+3.
  - Poly: last STEP cycle c gives res_valid at c+2.
- DONE:
  - res_valid=1 and res_data held stable until res_ready.
  - On res_valid&res_ready, return to IDLE; cmd_ready=1 the next cycle, with no same-cycle command acceptance.
- cmd_ready=0 and in_ready=0 in every state other than those listed above.
- Coefficient writes:
  - Writes are accepted only in IDLE and DONE; in all other states they are dropped, so no coefficient changes mid-command.
  - A write and a command in the same IDLE cycle: the write takes effect and the command uses the new value.
- The PE mac register is updated only when pe_en=1; pe_* outputs are stable registers, not combinational passthroughs.

Test Plan:
- Reset: rst high 3 cycles mid-STEP -> next cycle all outputs 0, state IDLE; cmd_ready=1 one cycle after release; no res_valid for the aborted command.
- MAC len=3, Z=10, beats (1,2),(3,4),(5,6) back-to-back, bench PE model -> pe_acc_en 0,1,1 on three consecutive pe_en cycles; res_valid 3 cycles after the last beat; res_data=54.
- MAC len=3, same data, in_valid low for 2 cycles between beats 1 and 2 -> pe_en gaps match the stall; res_data=54; len=0 command behaves as len=1.
- exp, TERMS=4, coefficients 0x101/0x102/0x103/0x104 written to idx 0..3 -> five pe_en cycles with pe_coeff 0x104,0x103,0x102,0x101,0x000; first_cycle only on cycle 1; last_cycle only on cycle 5; pe_op=10 throughout.
- Backpressure: res_ready low 5 cycles in DONE -> res_valid/res_data stable and cmd_ready=0 throughout; res_ready high -> IDLE; cmd_ready=1 the next cycle.
- cfg_we during STEP of a log command to cfg_op=11 idx 0 -> write dropped; issued coefficients equal the pre-command table.

Source files
------------

// File: rtl/uno_seq.sv
// rtl/uno_seq.sv - command sequencer and initiator for the unified MAC/div/exp/log PE
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_op (00 MAC, 01 div, 10 exp, 11 log), cmd_len (MAC beats)
//   in_valid/in_ready            operand beat handshake; in_x, in_y, in_z (MAC initial addend)
//   cfg_we/cfg_op/cfg_idx/cfg_data  coefficient table write port
//   pe_en, pe_op, pe_x, pe_y, pe_z, pe_coeff, pe_first_cycle, pe_last_cycle, pe_acc_en
//                                registered PE control and operands
//   pe_result                    PE accumulator output
//   res_valid/res_ready/res_data result handshake
module uno_seq #(
    parameter int MAC_BW = 12,
    parameter int TERMS  = 4,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MAC_BW-1:0]     in_x,
    input  logic [MAC_BW-1:0]     in_y,
    input  logic [2*MAC_BW-1:0]   in_z,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_op,
    input  logic [3:0]            cfg_idx,
    input  logic [MAC_BW-1:0]     cfg_data,
    output logic                  pe_en,
    output logic [1:0]            pe_op,
    output logic [MAC_BW-1:0]     pe_x,
    output logic [MAC_BW-1:0]     pe_y,
    output logic [2*MAC_BW-1:0]   pe_z,
    output logic [MAC_BW-1:0]     pe_coeff,
    output logic                  pe_first_cycle,
    output logic                  pe_last_cycle,
    output logic                  pe_acc_en,
    input  logic [2*MAC_BW-1:0]   pe_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*MAC_BW-1:0]   res_data
);

    localparam logic [3:0] TERMS_L = 4'(TERMS);
    localparam logic [1:0] OP_MAC  = 2'b00;

    typedef enum logic [2:0] {IDLE, STREAM, FETCH, STEP, CAPTURE, DONE} state_t;

    state_t             state, state_d;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_q, beat_d, beat_inc;
    logic [3:0]         s_q, s_d;

    // Row 0 (MAC) is never written; 16 columns so the 4-bit index addresses it directly.
    logic [MAC_BW-1:0]  coef [4][16];

    logic                 cmd_ready_d, in_ready_d, pe_en_d, first_d, last_d, acc_en_d, res_valid_d;
    logic [1:0]           pe_op_d;
    logic [MAC_BW-1:0]    pe_x_d, pe_y_d, pe_coeff_d;
    logic [2*MAC_BW-1:0]  pe_z_d, res_data_d;

    assign beat_inc = beat_q + 1'b1;

    // Next state and next value of every registered output. The outputs are
    // computed from the state being entered, so they line up with that state.
    always_comb begin
        state_d     = state;
        op_d        = op_q;
        len_d       = len_q;
        beat_d      = beat_q;
        s_d         = s_q;
        pe_en_d     = 1'b0;
        pe_op_d     = pe_op;
        pe_x_d      = pe_x;
        pe_y_d      = pe_y;
        pe_z_d      = pe_z;
        pe_coeff_d  = '0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        acc_en_d    = 1'b0;
        res_data_d  = res_data;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    len_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                    beat_d  = '0;
                    pe_op_d = cmd_op;
                    state_d = (cmd_op == OP_MAC) ? STREAM : FETCH;
                end
            end
            STREAM: begin
                if (in_valid && in_ready) begin
                    pe_x_d   = in_x;
                    pe_y_d   = in_y;
                    pe_z_d   = in_z;
                    pe_en_d  = 1'b1;
                    pe_op_d  = OP_MAC;
                    acc_en_d = (beat_q != '0);
                    beat_d   = beat_inc;
                    if (beat_inc == len_q)
                        state_d = CAPTURE;
                end
            end
            FETCH: begin
                if (in_valid && in_ready) begin
                    pe_x_d     = in_x;
                    pe_y_d     = in_y;
                    pe_z_d     = '0;
                    pe_en_d    = 1'b1;
                    first_d    = 1'b1;
                    pe_coeff_d = coef[op_q][TERMS_L - 4'd1];
                    s_d        = '0;
                    state_d    = STEP;
                end
            end
            STEP: begin
                if (s_q == TERMS_L) begin
                    state_d = CAPTURE;
                end else begin
                    s_d     = s_q + 4'd1;
                    pe_en_d = 1'b1;
                    if (s_d == TERMS_L)
                        last_d = 1'b1;
                    else
                        pe_coeff_d = coef[op_q][TERMS_L - 4'd1 - s_d];
                end
            end
            CAPTURE: begin
                // While the final pe_en is still on the PE, its accumulator
                // has not updated yet; capture one cycle later.
                if (!pe_en) begin
                    res_data_d = pe_result;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        in_ready_d  = (state_d == STREAM) || (state_d == FETCH);
        res_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            s_q            <= '0;
            cmd_ready      <= 1'b0;
            in_ready       <= 1'b0;
            pe_en          <= 1'b0;
            pe_op          <= '0;
            pe_x           <= '0;
            pe_y           <= '0;
            pe_z           <= '0;
            pe_coeff       <= '0;
            pe_first_cycle <= 1'b0;
            pe_last_cycle  <= 1'b0;
            pe_acc_en      <= 1'b0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            for (int r = 0; r < 4; r++)
                for (int i = 0; i < 16; i++)
                    coef[r][i] <= '0;
        end else begin
            state          <= state_d;
            op_q           <= op_d;
            len_q          <= len_d;
            beat_q         <= beat_d;
            s_q            <= s_d;
            cmd_ready      <= cmd_ready_d;
            in_ready       <= in_ready_d;
            pe_en          <= pe_en_d;
            pe_op          <= pe_op_d;
            pe_x           <= pe_x_d;
            pe_y           <= pe_y_d;
            pe_z           <= pe_z_d;
            pe_coeff       <= pe_coeff_d;
            pe_first_cycle <= first_d;
            pe_last_cycle  <= last_d;
            pe_acc_en      <= acc_en_d;
            res_valid      <= res_valid_d;
            res_data       <= res_data_d;
            // Table only changes between commands so an in-flight op sees a fixed set.
            if (cfg_we && (state == IDLE || state == DONE) && cfg_op != OP_MAC && cfg_idx < TERMS_L)
                coef[cfg_op][cfg_idx] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_uno_seq.sv
// tb/tb_uno_seq.sv - directed self-checking bench for uno_seq
module tb_uno_seq;

    localparam int MAC_BW = 12;
    localparam int TERMS  = 4;
    localparam int LEN_W  = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0, cmd_ready;
    logic [1:0]           cmd_op = '0;
    logic [LEN_W-1:0]     cmd_len = '0;
    logic                 in_valid = 1'b0, in_ready;
    logic [MAC_BW-1:0]    in_x = '0, in_y = '0;
    logic [2*MAC_BW-1:0]  in_z = '0;
    logic                 cfg_we = 1'b0;
    logic [1:0]           cfg_op = '0;
    logic [3:0]           cfg_idx = '0;
    logic [MAC_BW-1:0]    cfg_data = '0;
    logic                 pe_en, pe_first_cycle, pe_last_cycle, pe_acc_en;
    logic [1:0]           pe_op;
    logic [MAC_BW-1:0]    pe_x, pe_y, pe_coeff;
    logic [2*MAC_BW-1:0]  pe_z, pe_result;
    logic                 res_valid, res_ready = 1'b0;
    logic [2*MAC_BW-1:0]  res_data;

    uno_seq #(.MAC_BW(MAC_BW), .TERMS(TERMS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .pe_en(pe_en), .pe_op(pe_op), .pe_x(pe_x), .pe_y(pe_y), .pe_z(pe_z),
        .pe_coeff(pe_coeff), .pe_first_cycle(pe_first_cycle), .pe_last_cycle(pe_last_cycle),
        .pe_acc_en(pe_acc_en), .pe_result(pe_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PE model: MAC does z/acc + x*y; poly ops simply sum the issued coefficients.
    logic [2*MAC_BW-1:0] mac;
    assign pe_result = mac;
    always @(posedge clk) begin
        if (rst)
            mac <= '0;
        else if (pe_en) begin
            if (pe_op == 2'b00)
                mac <= (pe_acc_en ? mac : pe_z) + pe_x * pe_y;
            else
                mac <= pe_first_cycle ? {12'd0, pe_coeff} : mac + {12'd0, pe_coeff};
        end
    end

    // Log every pe_en cycle: cycle number, coefficient, {op, first, last, acc}.
    int               q_cyc[$];
    logic [11:0]      q_cf[$];
    logic [4:0]       q_fl[$];
    always @(negedge clk) begin
        if (!rst && pe_en) begin
            q_cyc.push_back(cyc);
            q_cf.push_back(pe_coeff);
            q_fl.push_back({pe_op, pe_first_cycle, pe_last_cycle, pe_acc_en});
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_cyc.delete();
        q_cf.delete();
        q_fl.delete();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        if (n == 20) check("cmd_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    int last_acc;
    task automatic send_beat(input logic [11:0] x, input logic [11:0] y, input logic [23:0] z);
        int n = 0;
        in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (n == 20) check("beat_timeout", 0, 1);
        tick();
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output int rc);
        int n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        if (n == 50) check("res_timeout", 0, 1);
        rc = cyc;
    endtask

    task automatic get_result(output logic [23:0] d, output int rc);
        wait_res(rc);
        d = res_data;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic wr_coef(input logic [1:0] op, input logic [3:0] idx, input logic [11:0] data);
        cfg_we = 1'b1; cfg_op = op; cfg_idx = idx; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic check_poly(input string tag, input logic [11:0] c0, input logic [1:0] op);
        check({tag, "_n"}, q_cyc.size(), 5);
        for (int i = 0; i < 5 && i < q_cyc.size(); i++) begin
            check({tag, "_coeff"}, q_cf[i], (i == 4) ? 12'h000 : c0 + 12'(3 - i));
            check({tag, "_flags"}, q_fl[i], {op, i == 0, i == 4, 1'b0});
            check({tag, "_consec"}, q_cyc[i] - q_cyc[0], i);
        end
    endtask

    logic [23:0] d;
    logic [23:0] d0;
    int          rc;
    int          seen;

    initial begin
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_pe_en", pe_en, 0);
        check("rst_res_valid", res_valid, 0);
        rst = 1'b0;
        tick();
        check("cmd_ready_after_rst", cmd_ready, 1);

        // MAC, back-to-back beats
        clear_log();
        send_cmd(2'b00, 8'd3);
        send_beat(12'd1, 12'd2, 24'd10);
        send_beat(12'd3, 12'd4, 24'd0);
        send_beat(12'd5, 12'd6, 24'd0);
        get_result(d, rc);
        check("mac_res", d, 54);
        check("mac_lat", rc - last_acc, 2);
        check("mac_n", q_cyc.size(), 3);
        if (q_cyc.size() == 3) begin
            check("mac_acc0", q_fl[0], 5'b00000);
            check("mac_acc1", q_fl[1], 5'b00001);
            check("mac_acc2", q_fl[2], 5'b00001);
            check("mac_consec", q_cyc[2] - q_cyc[0], 2);
        end
        check("mac_idle_ready", cmd_ready, 1);

        // MAC with a two-cycle stall between beats 1 and 2
        clear_log();
        send_cmd(2'b00, 8'd3);
        send_beat(12'd1, 12'd2, 24'd10);
        tick();
        tick();
        send_beat(12'd3, 12'd4, 24'd0);
        send_beat(12'd5, 12'd6, 24'd0);
        get_result(d, rc);
        check("stall_res", d, 54);
        check("stall_n", q_cyc.size(), 3);
        if (q_cyc.size() == 3) begin
            check("stall_gap", q_cyc[1] - q_cyc[0], 3);
            check("stall_gap2", q_cyc[2] - q_cyc[1], 1);
        end

        // len=0 behaves as one beat
        clear_log();
        send_cmd(2'b00, 8'd0);
        send_beat(12'd7, 12'd8, 24'd1);
        get_result(d, rc);
        check("len0_res", d, 57);
        check("len0_n", q_cyc.size(), 1);

        // exp with programmed table, plus result backpressure
        for (int i = 0; i < 4; i++) wr_coef(2'b10, 4'(i), 12'h101 + 12'(i));
        clear_log();
        send_cmd(2'b10, 8'd0);
        send_beat(12'd3, 12'd0, 24'd0);
        wait_res(rc);
        d0 = res_data;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, d0);
            check("bp_cmd_ready", cmd_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_release_valid", res_valid, 0);
        check("bp_release_ready", cmd_ready, 1);
        check("exp_res", d0, 24'h40A);
        check_poly("exp", 12'h101, 2'b10);
        if (q_cyc.size() == 5) check("exp_lat", rc - q_cyc[4], 2);

        // log: write during STEP is dropped
        for (int i = 0; i < 4; i++) wr_coef(2'b11, 4'(i), 12'h201 + 12'(i));
        clear_log();
        send_cmd(2'b11, 8'd0);
        send_beat(12'd2, 12'd0, 24'd0);
        wr_coef(2'b11, 4'd0, 12'hFFF);
        get_result(d, rc);
        check("log_res", d, 24'h80A);
        check_poly("log", 12'h201, 2'b11);

        // reset in the middle of STEP
        send_cmd(2'b11, 8'd0);
        send_beat(12'd2, 12'd0, 24'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_pe_en", pe_en, 0);
        check("mid_rst_coeff", pe_coeff, 0);
        check("mid_rst_pe_x", pe_x, 0);
        check("mid_rst_pe_op", pe_op, 0);
        check("mid_rst_flags", {pe_first_cycle, pe_last_cycle, pe_acc_en, in_ready}, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_res_data", res_data, 0);
        tick();
        tick();
        rst = 1'b0;
        check("rel_cmd_ready_low", cmd_ready, 0);
        tick();
        check("rel_cmd_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen++;
            tick();
        end
        check("abort_no_res", seen, 0);

        // table was cleared by reset
        send_cmd(2'b10, 8'd0);
        send_beat(12'd5, 12'd0, 24'd0);
        get_result(d, rc);
        check("cleared_table_res", d, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
